// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter sharing one data-memory channel among NUM_CONSUMERS LSUs.
// Reads win over writes on the granted consumer; a pending write is picked up by a later grant.
module dmem_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]                 consumer_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 consumer_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  consumer_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]                 consumer_write_ready,
    output logic                                     mem_read_valid,
    output logic [ADDR_BITS-1:0]                     mem_read_address,
    input  logic                                     mem_read_ready,
    input  logic [DATA_BITS-1:0]                     mem_read_data,
    output logic                                     mem_write_valid,
    output logic [ADDR_BITS-1:0]                     mem_write_address,
    output logic [DATA_BITS-1:0]                     mem_write_data,
    input  logic                                     mem_write_ready,
    output logic [$clog2(NUM_CONSUMERS)-1:0]         grant_id,
    output logic                                     busy
);
    localparam int IDW = $clog2(NUM_CONSUMERS);
    typedef enum logic [2:0] {IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY} state_t;
    state_t state, state_n;
    logic [IDW-1:0] rr_ptr, pick, pick_nxt;
    logic [IDW:0] s;
    logic [NUM_CONSUMERS-1:0] req;
    logic found, pick_rd;
    assign req  = consumer_read_valid | consumer_write_valid;
    assign busy = state != IDLE;
    // Descending scan so the consumer closest to rr_ptr is the last (winning) match.
    always_comb begin
        found = 1'b0;
        pick = '0;
        s = '0;
        for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
            s = {1'b0, rr_ptr} + (IDW+1)'(i);
            s = s >= (IDW+1)'(NUM_CONSUMERS) ? s - (IDW+1)'(NUM_CONSUMERS) : s;
            if (req[s[IDW-1:0]]) begin
                found = 1'b1;
                pick = s[IDW-1:0];
            end
        end
        pick_rd = consumer_read_valid[pick];
        pick_nxt = pick == IDW'(NUM_CONSUMERS - 1) ? '0 : pick + IDW'(1);
        state_n = state;
        case (state)
            IDLE:        state_n = !found ? IDLE : pick_rd ? READ_WAIT : WRITE_WAIT;
            READ_WAIT:   state_n = mem_read_ready ? READ_RELAY : READ_WAIT;
            WRITE_WAIT:  state_n = mem_write_ready ? WRITE_RELAY : WRITE_WAIT;
            READ_RELAY:  state_n = consumer_read_valid[grant_id] ? READ_RELAY : IDLE;
            WRITE_RELAY: state_n = consumer_write_valid[grant_id] ? WRITE_RELAY : IDLE;
            default:     state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant_id <= '0;
            mem_read_valid <= 1'b0;
            mem_read_address <= '0;
            mem_write_valid <= 1'b0;
            mem_write_address <= '0;
            mem_write_data <= '0;
            consumer_read_ready <= '0;
            consumer_write_ready <= '0;
            consumer_read_data <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (found) begin
                    grant_id <= pick;
                    rr_ptr <= pick_nxt;
                    mem_read_valid <= pick_rd;
                    mem_write_valid <= !pick_rd;
                    if (pick_rd) mem_read_address <= consumer_read_address[pick];
                    else begin
                        mem_write_address <= consumer_write_address[pick];
                        mem_write_data <= consumer_write_data[pick];
                    end
                end
                READ_WAIT: if (mem_read_ready) begin
                    mem_read_valid <= 1'b0;
                    consumer_read_data[grant_id] <= mem_read_data;
                    consumer_read_ready[grant_id] <= 1'b1;
                end
                WRITE_WAIT: if (mem_write_ready) begin
                    mem_write_valid <= 1'b0;
                    consumer_write_ready[grant_id] <= 1'b1;
                end
                READ_RELAY: if (!consumer_read_valid[grant_id]) consumer_read_ready <= '0;
                WRITE_RELAY: if (!consumer_write_valid[grant_id]) consumer_write_ready <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed scenarios plus randomized LSU traffic against a round-robin reference model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0] rv = '0, wv = '0, rrdy, wrdy;
    logic [3:0][7:0] ra = '0, wa = '0, wd = '0, rdat;
    logic mem_read_valid, mem_write_valid, mem_read_ready = 1'b0, mem_write_ready = 1'b0;
    logic [7:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data = '0;
    logic [1:0] gid;
    logic busy;
    int checks = 0, failures = 0;
    int mem_lat = 0, rcnt = 0, wcnt = 0;
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    dmem_arbiter #(.ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4)) dut (
        .clk(clk), .reset(reset),
        .consumer_read_valid(rv), .consumer_read_address(ra),
        .consumer_read_ready(rrdy), .consumer_read_data(rdat),
        .consumer_write_valid(wv), .consumer_write_address(wa),
        .consumer_write_data(wd), .consumer_write_ready(wrdy),
        .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready),
        .grant_id(gid), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural memory: answers mem_lat negedges after a request appears.
    always @(negedge clk) begin
        mem_read_ready = 1'b0;
        mem_write_ready = 1'b0;
        if (mem_read_valid) begin
            if (rcnt >= mem_lat) begin
                mem_read_ready = 1'b1;
                mem_read_data = mem[mem_read_address];
                rcnt = 0;
            end else rcnt++;
        end else rcnt = 0;
        if (mem_write_valid) begin
            if (wcnt >= mem_lat) begin
                mem_write_ready = 1'b1;
                mem[mem_write_address] = mem_write_data;
                wcnt = 0;
            end else wcnt++;
        end else wcnt = 0;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
        $fatal(1);
    end

    task automatic wait_bit(input bit w, input int c, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = w ? wrdy[c] : rrdy[c];
        end
    endtask

    task automatic apply_reset;
        @(negedge clk);
        reset = 1'b0;
        rv = '0;
        wv = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || mem_read_valid !== 1'b0 || mem_write_valid !== 1'b0 || gid !== 2'd0) begin
            failures++;
            $display("FAIL reset_ctrl busy=%b mrv=%b mwv=%b gid=%0d required all 0", busy, mem_read_valid, mem_write_valid, gid);
        end
        checks++;
        if (rrdy !== 4'b0 || wrdy !== 4'b0 || rdat !== 32'h0 || mem_read_address !== 8'h0 || mem_write_address !== 8'h0 || mem_write_data !== 8'h0) begin
            failures++;
            $display("FAIL reset_data rrdy=%b wrdy=%b rdat=%h mra=%h mwa=%h mwd=%h required all 0", rrdy, wrdy, rdat, mem_read_address, mem_write_address, mem_write_data);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_read;
        bit ok;
        mem_lat = 3;
        mem[8'h3C] = 8'hA5;
        ref_mem[8'h3C] = 8'hA5;
        @(negedge clk);
        ra[2] = 8'h3C;
        rv[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || gid !== 2'd2 || mem_read_valid !== 1'b1 || mem_read_address !== 8'h3C) begin
            failures++;
            $display("FAIL single_grant busy=%b gid=%0d mrv=%b addr=%h required 1 2 1 3c", busy, gid, mem_read_valid, mem_read_address);
        end
        wait_bit(1'b0, 2, ok);
        checks++;
        if (!ok || rdat[2] !== 8'hA5) begin
            failures++;
            $display("FAIL single_data ready_seen=%b data=%h required 1 a5", ok, rdat[2]);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (rrdy !== 4'b0100 || mem_read_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_hold rrdy=%b mrv=%b required 0100 0", rrdy, mem_read_valid);
        end
        rv[2] = 1'b0;
        @(negedge clk);
        checks++;
        if (rrdy !== 4'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_release rrdy=%b busy=%b required 0000 0", rrdy, busy);
        end
    endtask

    task automatic test_wrap;
        bit ok;
        mem_lat = 0;
        ra[0] = 8'h05;
        ra[3] = 8'h06;
        rv[0] = 1'b1;
        rv[3] = 1'b1;
        @(negedge clk);
        checks++;
        if (gid !== 2'd3 || mem_read_address !== 8'h06) begin
            failures++;
            $display("FAIL wrap_first gid=%0d addr=%h required 3 06", gid, mem_read_address);
        end
        wait_bit(1'b0, 3, ok);
        checks++;
        if (!ok || rdat[3] !== ref_mem[8'h06]) begin
            failures++;
            $display("FAIL wrap_data ready_seen=%b data=%h required 1 %h", ok, rdat[3], ref_mem[8'h06]);
        end
        rv[3] = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wrap_idle_gap busy=%b required 0", busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || gid !== 2'd0 || mem_read_address !== 8'h05) begin
            failures++;
            $display("FAIL wrap_second busy=%b gid=%0d addr=%h required 1 0 05", busy, gid, mem_read_address);
        end
        wait_bit(1'b0, 0, ok);
        rv[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_priority;
        bit ok, seen;
        mem_lat = 1;
        ra[1] = 8'h20;
        wa[1] = 8'h10;
        wd[1] = 8'h7E;
        rv[1] = 1'b1;
        wv[1] = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_read_valid !== 1'b1 || mem_write_valid !== 1'b0 || mem_read_address !== 8'h20 || gid !== 2'd1) begin
            failures++;
            $display("FAIL prio_read_first mrv=%b mwv=%b addr=%h gid=%0d required 1 0 20 1", mem_read_valid, mem_write_valid, mem_read_address, gid);
        end
        wait_bit(1'b0, 1, ok);
        rv[1] = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 20 && !seen; n++) begin
            @(negedge clk);
            seen = mem_write_valid;
        end
        checks++;
        if (!seen || mem_write_address !== 8'h10 || mem_write_data !== 8'h7E || gid !== 2'd1) begin
            failures++;
            $display("FAIL prio_write_next seen=%b addr=%h data=%h gid=%0d required 1 10 7e 1", seen, mem_write_address, mem_write_data, gid);
        end
        wait_bit(1'b1, 1, ok);
        checks++;
        if (!ok || mem[8'h10] !== 8'h7E) begin
            failures++;
            $display("FAIL prio_write_done ack=%b mem=%h required 1 7e", ok, mem[8'h10]);
        end
        ref_mem[8'h10] = 8'h7E;
        wv[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin;
        bit ok;
        int g;
        apply_reset();
        mem_lat = 0;
        ra = {8'h43, 8'h42, 8'h41, 8'h40};
        rv = 4'hF;
        for (int k = 0; k < 5; k++) begin
            ok = 1'b0;
            for (int n = 0; n < 20 && !ok; n++) begin
                @(negedge clk);
                ok = busy;
            end
            g = int'(gid);
            checks++;
            if (!ok || g != k % 4) begin
                failures++;
                $display("FAIL rr_order grant%0d busy=%b gid=%0d required %0d", k, ok, g, k % 4);
            end
            wait_bit(1'b0, g, ok);
            rv[g] = 1'b0;
            @(negedge clk);
            rv[g] = k < 4;
        end
        rv = '0;
        @(negedge clk);
    endtask

    task automatic test_stable_hold;
        bit ok;
        mem_lat = 3;
        ra[0] = 8'h11;
        rv[0] = 1'b1;
        @(negedge clk);
        checks++;
        if (gid !== 2'd0 || mem_read_address !== 8'h11) begin
            failures++;
            $display("FAIL hold_grant gid=%0d addr=%h required 0 11", gid, mem_read_address);
        end
        ra[0] = 8'h22;
        @(negedge clk);
        checks++;
        if (mem_read_address !== 8'h11) begin
            failures++;
            $display("FAIL hold_addr addr=%h required 11", mem_read_address);
        end
        wait_bit(1'b0, 0, ok);
        checks++;
        if (!ok || mem_read_address !== 8'h11 || rdat[0] !== ref_mem[8'h11]) begin
            failures++;
            $display("FAIL hold_done ready_seen=%b addr=%h data=%h required 1 11 %h", ok, mem_read_address, rdat[0], ref_mem[8'h11]);
        end
        rv[0] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read;
        bit ok;
        mem_lat = 6;
        ra[2] = 8'h33;
        rv[2] = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || gid !== 2'd2) begin
            failures++;
            $display("FAIL midrst_grant busy=%b gid=%0d required 1 2", busy, gid);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (mem_read_valid !== 1'b0 || busy !== 1'b0 || rrdy !== 4'b0 || wrdy !== 4'b0 || rdat !== 32'h0) begin
            failures++;
            $display("FAIL midrst_abort mrv=%b busy=%b rrdy=%b wrdy=%b rdat=%h required all 0", mem_read_valid, busy, rrdy, wrdy, rdat);
        end
        @(negedge clk);
        rv = '0;
        reset = 1'b1;
        ra[0] = 8'h01;
        ra[3] = 8'h02;
        rv = 4'b1001;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || gid !== 2'd0 || mem_read_address !== 8'h01) begin
            failures++;
            $display("FAIL midrst_regrant busy=%b gid=%0d addr=%h required 1 0 01", busy, gid, mem_read_address);
        end
        mem_lat = 0;
        wait_bit(1'b0, 0, ok);
        rv = '0;
        @(negedge clk);
    endtask

    task automatic test_random;
        int st[4], cnt[4];
        int mrr, exp_c, t, cyc;
        bit pbusy, found, done;
        logic [3:0] preq, prv, rdys;
        apply_reset();
        mrr = 0;
        pbusy = 1'b0;
        preq = '0;
        prv = '0;
        for (int ph = 0; ph < 3; ph++) begin
            mem_lat = ph * 2;
            for (int c = 0; c < 4; c++) begin
                st[c] = 0;
                cnt[c] = 6;
            end
            done = 1'b0;
            cyc = 0;
            while (!done && cyc < 3000) begin
                @(negedge clk);
                cyc++;
                if (!pbusy && preq != 4'b0) begin
                    found = 1'b0;
                    exp_c = 0;
                    for (int i = 0; i < 4; i++)
                        if (!found && preq[(mrr + i) % 4]) begin
                            found = 1'b1;
                            exp_c = (mrr + i) % 4;
                        end
                    checks++;
                    if (busy !== 1'b1 || int'(gid) != exp_c) begin
                        failures++;
                        $display("FAIL rand_grant busy=%b gid=%0d required 1 %0d", busy, gid, exp_c);
                    end
                    checks++;
                    if (prv[exp_c] ? (mem_read_valid !== 1'b1 || mem_read_address !== ra[exp_c])
                                   : (mem_write_valid !== 1'b1 || mem_write_address !== wa[exp_c] || mem_write_data !== wd[exp_c])) begin
                        failures++;
                        $display("FAIL rand_issue c=%0d rd=%b mrv=%b mra=%h mwv=%b mwa=%h mwd=%h required ra=%h wa=%h wd=%h",
                                 exp_c, prv[exp_c], mem_read_valid, mem_read_address, mem_write_valid, mem_write_address, mem_write_data, ra[exp_c], wa[exp_c], wd[exp_c]);
                    end
                    if (!prv[exp_c]) ref_mem[wa[exp_c]] = wd[exp_c];
                    mrr = (exp_c + 1) % 4;
                end else if (!pbusy && busy) begin
                    checks++;
                    failures++;
                    $display("FAIL rand_spurious_grant gid=%0d required no grant", gid);
                end
                rdys = rrdy | wrdy;
                checks++;
                if ($countones(rdys) > 1 || (rdys & ~(4'b1 << gid)) != 4'b0) begin
                    failures++;
                    $display("FAIL rand_ready_onehot rrdy=%b wrdy=%b gid=%0d required only granted bit", rrdy, wrdy, gid);
                end
                for (int c = 0; c < 4; c++) begin
                    if (st[c] == 1 && rrdy[c]) begin
                        checks++;
                        if (rdat[c] !== ref_mem[ra[c]]) begin
                            failures++;
                            $display("FAIL rand_read_data c=%0d addr=%h data=%h required %h", c, ra[c], rdat[c], ref_mem[ra[c]]);
                        end
                        rv[c] = 1'b0;
                        if (wv[c]) st[c] = 2;
                        else begin
                            st[c] = 0;
                            cnt[c]--;
                        end
                    end else if (st[c] == 2 && wrdy[c]) begin
                        wv[c] = 1'b0;
                        st[c] = 0;
                        cnt[c]--;
                    end else if (st[c] == 0 && cnt[c] > 0 && $urandom_range(0, 2) != 0) begin
                        t = $urandom_range(0, 2);
                        ra[c] = 8'($urandom_range(0, 15));
                        wa[c] = 8'($urandom_range(0, 15));
                        wd[c] = 8'($urandom);
                        rv[c] = t != 1;
                        wv[c] = t != 0;
                        st[c] = t == 1 ? 2 : 1;
                    end
                end
                pbusy = busy;
                prv = rv;
                preq = rv | wv;
                done = busy == 1'b0 && preq == 4'b0;
                for (int c = 0; c < 4; c++) done = done && cnt[c] == 0 && st[c] == 0;
            end
            checks++;
            if (!done) begin
                failures++;
                $display("FAIL rand_timeout phase=%0d cycles=%0d required completion within 3000", ph, cyc);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        test_reset();
        test_single_read();
        test_wrap();
        test_priority();
        test_round_robin();
        test_stable_hold();
        test_reset_mid_read();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
